// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline sequencing controller.
//   - state_e      : FSM state encoding (RUN=0, MD_WAIT=1)
//   - NopInstr     : instruction word the IF/ID register loads when flushed
//   - MdCntW       : width of the mul/div hold counter (covers MULDIV_CYCLES up to 16)
package hazard_ctrl_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StMdWait = 1'b1
  } state_e;

  localparam logic [31:0] NopInstr = 32'h0000_0000;

  localparam int unsigned MdCntW = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of hazard-detection inputs and pipeline control outputs.
//   master : the pipeline side, drives ID/EX status and perf_clr, receives controls
//   slave  : hazard_ctrl, receives status and drives enables/bubbles/counters
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import hazard_ctrl_pkg::*;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_muldiv;
  logic             ex_mread;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             perf_clr;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_muldiv, ex_mread, ex_rt, ex_branch_taken, perf_clr,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, md_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_muldiv, ex_mread, ex_rt, ex_branch_taken, perf_clr,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, md_busy,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// hazard_ctrl_sat_counter: saturating event counter (sat_counter).
//   clock   : core clock, rising edge
//   rst     : asynchronous active-high reset, clears the count
//   i_inc   : count one event this cycle
//   i_clr   : synchronous clear, wins over i_inc
//   o_count : current count, sticks at all-ones
module hazard_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//   clock : core clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : hazard_ctrl_if slave; ID/EX hazard status in, PC/IF-ID/ID-EX/EX-MEM controls
//           and stall/flush event counters out
// Handles taken-branch squash, single-cycle load-use stall and the fixed-latency
// mul/div hold in EX. Controls are combinational from state plus inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clock,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);

  // The RUN cycle that issues the mul/div counts as one of its EX cycles, so the
  // hold lasts MULDIV_CYCLES-1 cycles and the counter starts at MULDIV_CYCLES-2.
  localparam logic [MdCntW-1:0] MdLoad =
      MdCntW'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);
  localparam bit MdEnable = (MULDIV_CYCLES > 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [MdCntW-1:0] r_md_cnt;
  logic [MdCntW-1:0] w_md_cnt_next;
  logic              w_lu;
  logic              w_stall_inc;
  logic              w_flush_inc;

  // Register 0 is hard-wired zero, so a load targeting it is never a real dependency.
  assign w_lu = bus.ex_mread && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state  <= StRun;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_md_cnt <= w_md_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_md_cnt_next    = r_md_cnt;
    w_stall_inc      = 1'b0;
    w_flush_inc      = 1'b0;
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_en      = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.exmem_bubble = 1'b0;
    bus.md_busy      = 1'b0;

    unique case (r_state)
      StRun: begin
        if (bus.ex_branch_taken) begin
          // The ID instruction is on the wrong path; its hazards are irrelevant.
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
          w_flush_inc     = 1'b1;
        end else if (w_lu) begin
          bus.pc_en       = 1'b0;
          bus.ifid_en     = 1'b0;
          bus.idex_bubble = 1'b1;
          w_stall_inc     = 1'b1;
        end else if (bus.id_muldiv && MdEnable) begin
          w_state_next  = StMdWait;
          w_md_cnt_next = MdLoad;
        end
      end
      StMdWait: begin
        // Mul/div stays in EX; everything behind it freezes and MEM gets bubbles.
        bus.pc_en        = 1'b0;
        bus.ifid_en      = 1'b0;
        bus.idex_en      = 1'b0;
        bus.exmem_bubble = 1'b1;
        bus.md_busy      = 1'b1;
        w_stall_inc      = 1'b1;
        if (r_md_cnt == '0) begin
          w_state_next = StRun;
        end else begin
          w_md_cnt_next = r_md_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = StRun;
      end
    endcase

    // Reset is asynchronous, so the controls must go benign without waiting for a clock.
    if (rst) begin
      bus.pc_en        = 1'b1;
      bus.ifid_en      = 1'b1;
      bus.ifid_flush   = 1'b0;
      bus.idex_en      = 1'b1;
      bus.idex_bubble  = 1'b0;
      bus.exmem_bubble = 1'b0;
      bus.md_busy      = 1'b0;
    end
  end

  hazard_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .rst     (rst),
    .i_inc   (w_stall_inc),
    .i_clr   (bus.perf_clr),
    .o_count (bus.stall_cnt)
  );

  hazard_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clock   (clock),
    .rst     (rst),
    .i_inc   (w_flush_inc),
    .i_clr   (bus.perf_clr),
    .o_count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MULDIV_CYCLES=4, CNT_W=4).
module tb_hazard_ctrl;

  logic clock;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(
    .MULDIV_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rt      = 1'b0;
    bus.id_muldiv       = 1'b0;
    bus.ex_mread        = 1'b0;
    bus.ex_rt           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.perf_clr        = 1'b0;
  endtask

  task automatic set_lu();
    bus.ex_mread = 1'b1;
    bus.ex_rt    = 5'd5;
    bus.id_rs    = 5'd5;
  endtask

  // Advance one clock and land on the falling edge, where inputs change and outputs settle.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b1;
    set_lu();
    #12;
    // Reset forces benign controls even with a hazard present.
    chk("rst_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rst_ifid_en", 32'(bus.ifid_en), 32'd1);
    chk("rst_idex_bubble", 32'(bus.idex_bubble), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clock);
    rst = 1'b0;
    idle();
    step();

    // 1: load-use single stall
    set_lu();
    #1;
    chk("lu_pc_en", 32'(bus.pc_en), 32'd0);
    chk("lu_ifid_en", 32'(bus.ifid_en), 32'd0);
    chk("lu_idex_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("lu_idex_en", 32'(bus.idex_en), 32'd1);
    step();
    idle();
    #1;
    chk("lu_after_pc_en", 32'(bus.pc_en), 32'd1);
    chk("lu_after_bubble", 32'(bus.idex_bubble), 32'd0);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // perf_clr brings counters back to zero
    bus.perf_clr = 1'b1;
    step();
    bus.perf_clr = 1'b0;
    chk("clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // 2: taken branch beats load-use
    set_lu();
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    chk("br_idex_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("br_pc_en", 32'(bus.pc_en), 32'd1);
    chk("br_ifid_en", 32'(bus.ifid_en), 32'd1);
    step();
    idle();
    #1;
    chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // 3: mul/div hold for 3 cycles; a taken branch during the hold is ignored
    bus.id_muldiv = 1'b1;
    #1;
    chk("md_issue_pc_en", 32'(bus.pc_en), 32'd1);
    chk("md_issue_busy", 32'(bus.md_busy), 32'd0);
    step();
    bus.id_muldiv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ex_branch_taken = (i == 1);
      #1;
      chk("md_busy", 32'(bus.md_busy), 32'd1);
      chk("md_idex_en", 32'(bus.idex_en), 32'd0);
      chk("md_exmem_bubble", 32'(bus.exmem_bubble), 32'd1);
      chk("md_pc_en", 32'(bus.pc_en), 32'd0);
      chk("md_ifid_flush", 32'(bus.ifid_flush), 32'd0);
      step();
    end
    bus.ex_branch_taken = 1'b0;
    #1;
    chk("md_done_busy", 32'(bus.md_busy), 32'd0);
    chk("md_done_pc_en", 32'(bus.pc_en), 32'd1);
    chk("md_stall_cnt", 32'(bus.stall_cnt), 32'd3);
    chk("md_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // 4: register 0 and unused rt never stall; used rt does
    bus.ex_mread = 1'b1;
    bus.ex_rt    = 5'd0;
    bus.id_rs    = 5'd0;
    #1;
    chk("r0_pc_en", 32'(bus.pc_en), 32'd1);
    chk("r0_bubble", 32'(bus.idex_bubble), 32'd0);
    bus.ex_rt      = 5'd7;
    bus.id_rt      = 5'd7;
    bus.id_rs      = 5'd3;
    bus.id_uses_rt = 1'b0;
    #1;
    chk("rt_unused_pc_en", 32'(bus.pc_en), 32'd1);
    bus.id_uses_rt = 1'b1;
    #1;
    chk("rt_used_pc_en", 32'(bus.pc_en), 32'd0);
    step();
    idle();
    chk("rt_stall_cnt", 32'(bus.stall_cnt), 32'd4);

    // 5: reset during the 2nd MD_WAIT cycle
    bus.id_muldiv = 1'b1;
    step();
    bus.id_muldiv = 1'b0;
    step();
    chk("rstmd_busy_before", 32'(bus.md_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmd_busy", 32'(bus.md_busy), 32'd0);
    chk("rstmd_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rstmd_idex_en", 32'(bus.idex_en), 32'd1);
    chk("rstmd_exmem_bubble", 32'(bus.exmem_bubble), 32'd0);
    chk("rstmd_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rstmd_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmd_after_busy", 32'(bus.md_busy), 32'd0);
    end

    // 6: saturation at 15, then clear beats a simultaneous stall
    set_lu();
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
    bus.perf_clr = 1'b1;
    step();
    chk("sat_clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    bus.perf_clr = 1'b0;
    step();
    chk("sat_restart_cnt", 32'(bus.stall_cnt), 32'd1);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. It drives the enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards against the instruction in EX and squashes wrong-path instructions on a taken branch resolved in EX.
- Holds the pipeline for the fixed latency of a multi-cycle mul/div in EX.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- MULDIV_CYCLES, 4, total EX occupancy of a mul/div instruction in cycles; legal range 1..16.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clock  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source
- id_muldiv  in  1  instruction in ID is mul/div
- ex_mread  in  1  MRead of the instruction in EX (ID/EX MReadreg)
- ex_rt  in  5  rt of the instruction in EX (ID/EX RegRtreg)
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- perf_clr  in  1  synchronous clear of both event counters
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_en  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads all-zero control (WB, RegWrite, MRead, MWrite = 0)
- exmem_bubble  out  1  EX/MEM loads all-zero control
- md_busy  out  1  FSM in MD_WAIT
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Interface: one clock, `clock`. Reset `rst` is asynchronous and active-high.
- While rst=1:
  - FSM=RUN, md counter=0, stall_cnt=0, flush_cnt=0.
  - Outputs forced to pc_en=1, ifid_en=1, idex_en=1, all flush/bubble=0, md_busy=0.
  - Reset mid-MD_WAIT abandons the wait immediately.
- FSM states: RUN and MD_WAIT. Control outputs are combinational from state plus inputs; state and counters are registered.
- Load-use hazard, lu: ex_mread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN, priority order:
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, enables=1. lu and id_muldiv are ignored (the ID instruction is squashed). flush_cnt+1.
  2. lu: pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1. Exactly one stall cycle, because the load moves to MEM and lu clears. stall_cnt+1.
  3. id_muldiv & MULDIV_CYCLES>1: normal advance this cycle. Next state MD_WAIT, md counter = MULDIV_CYCLES-2.
  4. Otherwise all enables=1, bubbles/flush=0.
- MD_WAIT:
  - Outputs: pc_en=0, ifid_en=0, idex_en=0 (mul/div held in EX), exmem_bubble=1, md_busy=1. stall_cnt+1 each cycle.
  - If counter==0, next state RUN; else counter-1. Total hold = MULDIV_CYCLES-1 cycles.
  - ex_branch_taken and lu are ignored in MD_WAIT.
- MULDIV_CYCLES=1: MD_WAIT is never entered.
- Counters:
  - Saturate at all-ones with no wrap.
  - perf_clr has priority over the increment in the same cycle: the result is 0.
- Register 0 never causes a load-use stall.

Decomposition:
- Shared package: the FSM state encoding (RUN=0, MD_WAIT=1) and the NOP instruction constant used by the IF/ID flush.
- One sub-module, sat_counter (CNT_W width; inputs inc and clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
1. Load-use:
   - Stimulus: ex_mread=1, ex_rt=5, id_rs=5.
   - Required: one cycle of pc_en=0, ifid_en=0, idex_bubble=1; next cycle normal; stall_cnt=1.
2. Branch beats load-use:
   - Stimulus: ex_branch_taken=1 with the same lu condition as scenario 1.
   - Required: ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt=0.
3. Mul/div hold, MULDIV_CYCLES=4:
   - Stimulus: id_muldiv=1 for one cycle.
   - Required: exactly 3 cycles with md_busy=1, idex_en=0, exmem_bubble=1; then RUN; stall_cnt=3.
4. Register 0 and rt usage:
   - Stimulus A: ex_rt=0, id_rs=0, ex_mread=1. Required: no stall.
   - Stimulus B: ex_rt=7, id_rt=7, id_uses_rt=0. Required: no stall.
5. Reset mid-operation:
   - Stimulus: assert rst on the 2nd MD_WAIT cycle, between clock edges.
   - Required: outputs immediately return to enables=1, md_busy=0, counters=0; no MD_WAIT after release.
6. Counter saturation, CNT_W=4:
   - Stimulus: 20 consecutive lu cycles.
   - Required: stall_cnt holds at 15. perf_clr with a simultaneous stall gives 0.
